// File: rtl/sign_mag_accum.sv
// sign_mag_accum: saturating sign-magnitude accumulator with valid/ready input and one-cycle update strobe.
// Ports: clk, reset (async, active-high), clear (sync, highest priority),
//        in_valid/in_ready/in_data (IN_W-bit sign-magnitude operand),
//        acc (W-bit sign-magnitude total), acc_valid (update strobe), sat (saturation flag).
// Build option: define SM_ACC_STICKY_SAT_EN to make sat sticky until clear/reset.
module sign_mag_accum #(
  parameter int IN_W = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic [W-1:0]    acc,
  output logic            acc_valid,
  output logic            sat
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t          r_state, w_next;
  logic [IN_W-1:0] r_op;
  logic [W-1:0]    r_acc;
  logic            r_acc_valid, r_sat;
  logic            w_accept, w_op_sign, w_acc_sign, w_same, w_acc_ge, w_sat, w_sign;
  logic [W-2:0]    w_op_mag, w_acc_mag, w_mag;
  logic [W-1:0]    w_sum;
  assign in_ready  = (r_state == IDLE) && !clear;
  assign w_accept  = in_valid && in_ready;
  assign acc       = r_acc;
  assign acc_valid = r_acc_valid;
  assign sat       = r_sat;
  assign w_op_sign  = r_op[IN_W-1];
  assign w_op_mag   = {{(W-IN_W){1'b0}}, r_op[IN_W-2:0]};
  assign w_acc_sign = r_acc[W-1];
  assign w_acc_mag  = r_acc[W-2:0];
  assign w_same     = w_op_sign == w_acc_sign;
  assign w_acc_ge   = w_acc_mag >= w_op_mag;
  // one extra bit on the magnitude sum exposes overflow past 2^(W-1)-1
  assign w_sum      = {1'b0, w_acc_mag} + {1'b0, w_op_mag};
  assign w_sat      = w_same && w_sum[W-1];
  always_comb begin
    w_mag  = w_same ? (w_sat ? {(W-1){1'b1}} : w_sum[W-2:0])
                    : (w_acc_ge ? w_acc_mag - w_op_mag : w_op_mag - w_acc_mag);
    // zero magnitude always carries a + sign, which also folds a -0 operand
    w_sign = (w_same ? w_acc_sign : (w_acc_ge ? w_acc_sign : w_op_sign)) && (w_mag != '0);
  end
  always_comb begin
    w_next = r_state;
    if (clear)               w_next = IDLE;
    else if (w_accept)       w_next = CALC;
    else if (r_state == CALC) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_acc_valid <= 1'b0;
      if (clear) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (w_accept) begin
        r_op <= in_data;
      end else if (r_state == CALC) begin
        r_acc       <= {w_sign, w_mag};
        r_acc_valid <= 1'b1;
`ifdef SM_ACC_STICKY_SAT_EN
        r_sat       <= r_sat | w_sat;
`else
        r_sat       <= w_sat;
`endif
      end
    end
  end
endmodule
